// File: rtl/interrupt_unit.sv
// interrupt_unit: interrupt/CP0 stage that sits behind the instruction decoder.
// It synchronises three external requests, picks the highest-priority one,
// saves the return PC (EPC), redirects fetch to a per-source vector and
// restores the PC on eret. It also owns the global interrupt-enable bit and
// serves mfc/mtc access to EPC.
//
// Build option: define NESTED_INT_EN to let a strictly higher-priority source
// preempt a running ISR. EPC then becomes a stack NSRC entries deep. Without
// it, EPC is a single register and no take happens while any ISR is active.
module interrupt_unit #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0040,
  parameter int          NSRC       = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] irq,
  input  logic [4:0]      int_ctrl,
  input  logic            halt,
  input  logic [31:0]     pc_ret,
  input  logic [31:0]     cp0_wdata,
  output logic            int_take,
  output logic [31:0]     int_vector,
  output logic            eret_take,
  output logic [31:0]     epc,
  output logic [31:0]     cp0_rdata,
  output logic            ie,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] in_service
);

  // Rank encoding: index of the highest set bit plus one, zero when empty.
  localparam int RW = $clog2(NSRC + 1);

  typedef enum logic {
    RUN   = 1'b0,
    ENTER = 1'b1
  } state_t;

  state_t state, state_next;

  logic ctl_eret, ctl_cli, ctl_sti, ctl_mtc, ctl_mfc;

  logic [NSRC-1:0] sync_a, sync_b, irq_prev, irq_rise;
  logic [RW-1:0]   pend_rank, serv_rank;
  logic [RW-1:0]   take_idx, serv_idx;
  logic            rank_ok, take, eret_pop;
  logic [NSRC-1:0] take_mask, clear_mask;

  function automatic logic [RW-1:0] top_rank(input logic [NSRC-1:0] v);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (v[i]) r = RW'(i + 1);
    end
    return r;
  endfunction

  assign {ctl_eret, ctl_cli, ctl_sti, ctl_mtc, ctl_mfc} = int_ctrl;

  assign irq_rise  = sync_b & ~irq_prev;
  assign pend_rank = top_rank(pending);
  assign serv_rank = top_rank(in_service);
  assign take_idx  = pend_rank - RW'(1);
  assign serv_idx  = serv_rank - RW'(1);
  assign eret_pop  = ctl_eret && (in_service != '0);

  assign take_mask  = take     ? (NSRC'(1) << take_idx) : '0;
  assign clear_mask = eret_pop ? (NSRC'(1) << serv_idx) : '0;

`ifdef NESTED_INT_EN
  // A pending source may only interrupt something of strictly lower priority.
  assign rank_ok = (pend_rank > serv_rank);
`else
  // Single-level: any pending source, but only while no ISR is running.
  assign rank_ok = (pending != '0) && (in_service == '0);
`endif

  // Two-flop synchroniser followed by the edge-detect register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a   <= '0;
      sync_b   <= '0;
      irq_prev <= '0;
    end else begin
      sync_a   <= irq;
      sync_b   <= sync_a;
      irq_prev <= sync_b;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Take decision; ENTER spends one cycle so a second take cannot follow at once.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      RUN: begin
        if (ie && !halt && !ctl_eret && !ctl_cli && rank_ok) begin
          take       = 1'b1;
          state_next = ENTER;
        end
      end
      ENTER:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Request latching, service tracking and the global enable bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      in_service <= '0;
      ie         <= 1'b1;
    end else begin
      pending    <= (pending & ~take_mask) | irq_rise;
      in_service <= (in_service | take_mask) & ~clear_mask;
      if (take)          ie <= 1'b0;
      else if (eret_pop) ie <= 1'b1;
      else if (ctl_sti)  ie <= 1'b1;
      else if (ctl_cli)  ie <= 1'b0;
    end
  end

  // One-cycle redirect pulses towards fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_take   <= 1'b0;
      int_vector <= '0;
      eret_take  <= 1'b0;
    end else begin
      int_take   <= take;
      int_vector <= take ? (VEC_BASE + VEC_STRIDE * 32'(take_idx)) : '0;
      eret_take  <= ctl_eret;
    end
  end

`ifdef NESTED_INT_EN
  // Stack depth always equals the number of active ISRs, because each
  // source can be in service at most once and preemption only goes upwards.
  logic [31:0]   epc_stack [NSRC];
  logic [RW-1:0] depth, top_idx;
  logic          pop_shown;

  // Count active ISRs to find the stack depth.
  always_comb begin
    depth = '0;
    for (int i = 0; i < NSRC; i++) begin
      depth = depth + RW'(in_service[i]);
    end
  end

  assign top_idx = (depth == '0) ? '0 : (depth - RW'(1));

  // Push on take, overwrite the top on mtc. A pop leaves the entry in place
  // so it can still be shown during the eret_take pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSRC; i++) epc_stack[i] <= '0;
      pop_shown <= 1'b0;
    end else begin
      pop_shown <= eret_pop;
      if (take)         epc_stack[depth]   <= pc_ret;
      else if (ctl_mtc) epc_stack[top_idx] <= cp0_wdata;
    end
  end

  assign epc = pop_shown ? epc_stack[depth] : epc_stack[top_idx];
`else
  logic [31:0] epc_reg;

  // Single EPC register: loaded on take, overwritten by mtc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       epc_reg <= '0;
    else if (take)    epc_reg <= pc_ret;
    else if (ctl_mtc) epc_reg <= cp0_wdata;
  end

  assign epc = epc_reg;
`endif

  assign cp0_rdata = ctl_mfc ? epc : '0;

endmodule

// File: tb/tb_interrupt_unit.sv
// Self-checking bench for interrupt_unit: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_interrupt_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  irq;
  logic [4:0]  int_ctrl;
  logic        halt;
  logic [31:0] pc_ret;
  logic [31:0] cp0_wdata;
  logic        int_take;
  logic [31:0] int_vector;
  logic        eret_take;
  logic [31:0] epc;
  logic [31:0] cp0_rdata;
  logic        ie;
  logic [2:0]  pending;
  logic [2:0]  in_service;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_MFC  = 5'b00001;
  localparam logic [4:0] C_MTC  = 5'b00010;
  localparam logic [4:0] C_STI  = 5'b00100;
  localparam logic [4:0] C_CLI  = 5'b01000;
  localparam logic [4:0] C_ERET = 5'b10000;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [2:0]  m_pending;
  int          m_svc[$];
  logic [31:0] m_stk[$];
  logic        m_ie;
  logic [31:0] m_idle;
  logic        m_int_take;
  logic        m_eret_take;
  logic [31:0] m_vector;
  logic [31:0] m_epc;
  logic [2:0]  m_hist[$];

  interrupt_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq        (irq),
    .int_ctrl   (int_ctrl),
    .halt       (halt),
    .pc_ret     (pc_ret),
    .cp0_wdata  (cp0_wdata),
    .int_take   (int_take),
    .int_vector (int_vector),
    .eret_take  (eret_take),
    .epc        (epc),
    .cp0_rdata  (cp0_rdata),
    .ie         (ie),
    .pending    (pending),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] svcBits();
    logic [2:0] b;
    b = '0;
    foreach (m_svc[i]) b[m_svc[i]] = 1'b1;
    return b;
  endfunction

  task automatic modelReset();
    m_pending   = '0;
    m_svc.delete();
    m_stk.delete();
    m_ie        = 1'b1;
    m_idle      = '0;
    m_int_take  = 1'b0;
    m_eret_take = 1'b0;
    m_vector    = '0;
    m_epc       = '0;
    m_hist.delete();
    for (int i = 0; i < 3; i++) m_hist.push_back(3'b000);
  endtask

  // Advance the model by one clock edge using the inputs held across it.
  // m_hist[0] is irq at the previous edge, m_hist[1] two edges back, etc.
  task automatic modelStep();
    logic [2:0]  rise;
    int          hp;
    int          hs;
    logic        tk;
    logic        show_pop;
    logic [31:0] popped;
    int          mi;
    rise = m_hist[1] & ~m_hist[2];
    m_hist.push_front(irq);
    m_hist.delete(3);
    hp = -1;
    for (int k = 0; k < 3; k++) if (m_pending[k]) hp = k;
    hs = -1;
    foreach (m_svc[i]) if (m_svc[i] > hs) hs = m_svc[i];
`ifdef NESTED_INT_EN
    tk = m_ie && !halt && !int_ctrl[4] && !int_ctrl[3] && !m_int_take && (hp >= 0) && (hp > hs);
`else
    tk = m_ie && !halt && !int_ctrl[4] && !int_ctrl[3] && !m_int_take && (hp >= 0) && (m_svc.size() == 0);
`endif
    show_pop    = 1'b0;
    popped      = '0;
    m_eret_take = int_ctrl[4];
    m_int_take  = tk;
    m_vector    = tk ? (32'h800 + 32'(hp) * 32'h40) : 32'h0;
    if (tk) begin
      m_stk.push_back(pc_ret);
      m_svc.push_back(hp);
      m_pending[hp] = 1'b0;
      m_ie = 1'b0;
    end else if (int_ctrl[4] && (m_svc.size() > 0)) begin
      popped = m_stk.pop_back();
      mi = 0;
      foreach (m_svc[i]) if (m_svc[i] > m_svc[mi]) mi = i;
      m_svc.delete(mi);
      m_ie = 1'b1;
      show_pop = 1'b1;
      if (m_stk.size() == 0) m_idle = popped;
    end else begin
      if (int_ctrl[2]) m_ie = 1'b1;
      if (int_ctrl[3]) m_ie = 1'b0;
      if (int_ctrl[1]) begin
        if (m_stk.size() > 0) m_stk[m_stk.size()-1] = cp0_wdata;
        else                  m_idle = cp0_wdata;
      end
    end
    m_pending = m_pending | rise;
    if (show_pop)               m_epc = popped;
    else if (m_stk.size() > 0)  m_epc = m_stk[m_stk.size()-1];
    else                        m_epc = m_idle;
  endtask

  task automatic checkAll();
    checkOutput("int_take", {31'b0, int_take}, {31'b0, m_int_take});
    if (m_int_take) checkOutput("int_vector", int_vector, m_vector);
    checkOutput("eret_take", {31'b0, eret_take}, {31'b0, m_eret_take});
    checkOutput("epc", epc, m_epc);
    checkOutput("ie", {31'b0, ie}, {31'b0, m_ie});
    checkOutput("pending", {29'b0, pending}, {29'b0, m_pending});
    checkOutput("in_service", {29'b0, in_service}, {29'b0, svcBits()});
  endtask

  // Drive one cycle of inputs, check cp0_rdata before the edge and all
  // registered outputs just after it.
  task automatic applyStimulus(input logic [2:0] i_irq, input logic [4:0] i_ctrl, input logic i_halt,
                               input logic [31:0] i_pc, input logic [31:0] i_wd);
    irq       = i_irq;
    int_ctrl  = i_ctrl;
    halt      = i_halt;
    pc_ret    = i_pc;
    cp0_wdata = i_wd;
    #1;
    checkOutput("cp0_rdata", cp0_rdata, int_ctrl[0] ? m_epc : 32'h0);
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic idleCycles(input logic [2:0] i_irq, input logic [31:0] i_pc, input int n);
    for (int i = 0; i < n; i++) applyStimulus(i_irq, C_NONE, 1'b0, i_pc, 32'h0);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_int_take", {31'b0, int_take}, 32'h0);
    checkOutput("rst_int_vector", int_vector, 32'h0);
    checkOutput("rst_eret_take", {31'b0, eret_take}, 32'h0);
    checkOutput("rst_epc", epc, 32'h0);
    checkOutput("rst_ie", {31'b0, ie}, 32'h1);
    checkOutput("rst_pending", {29'b0, pending}, 32'h0);
    checkOutput("rst_in_service", {29'b0, in_service}, 32'h0);
  endtask

  initial begin
    logic [2:0]  r_irq;
    logic [4:0]  r_ctrl;
    int          r;

    rst_n     = 1'b0;
    irq       = '0;
    int_ctrl  = C_NONE;
    halt      = 1'b0;
    pc_ret    = '0;
    cp0_wdata = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    checkResetValues();
    rst_n = 1'b1;

    // Single request on source 1
    $display("[TB] single request on irq[1]");
    idleCycles(3'b010, 32'h100, 3);
    checkOutput("t1_pending", {29'b0, pending}, 32'h2);
    checkOutput("t1_no_take_yet", {31'b0, int_take}, 32'h0);
    idleCycles(3'b010, 32'h100, 1);
    checkOutput("t1_int_take", {31'b0, int_take}, 32'h1);
    checkOutput("t1_vector", int_vector, 32'h840);
    checkOutput("t1_epc", epc, 32'h100);
    checkOutput("t1_ie", {31'b0, ie}, 32'h0);
    checkOutput("t1_in_service", {29'b0, in_service}, 32'h2);
    applyStimulus(3'b010, C_ERET, 1'b0, 32'h104, 32'h0);
    checkOutput("t1_eret_take", {31'b0, eret_take}, 32'h1);
    checkOutput("t1_eret_epc", epc, 32'h100);
    checkOutput("t1_eret_in_service", {29'b0, in_service}, 32'h0);
    checkOutput("t1_eret_ie", {31'b0, ie}, 32'h1);
    idleCycles(3'b000, 32'h104, 4);

    // Simultaneous requests on sources 0 and 2
    $display("[TB] simultaneous irq[0] and irq[2]");
    idleCycles(3'b101, 32'h200, 4);
    checkOutput("t2_vector_src2", int_vector, 32'h880);
    checkOutput("t2_in_service", {29'b0, in_service}, 32'h4);
    checkOutput("t2_pending_src0", {29'b0, pending}, 32'h1);
    idleCycles(3'b101, 32'h880, 2);
    applyStimulus(3'b101, C_ERET, 1'b0, 32'h200, 32'h0);
    checkOutput("t2_eret_epc", epc, 32'h200);
    idleCycles(3'b101, 32'h200, 1);
    checkOutput("t2_take_src0", {31'b0, int_take}, 32'h1);
    checkOutput("t2_vector_src0", int_vector, 32'h800);
    checkOutput("t2_epc_src0", epc, 32'h200);
    applyStimulus(3'b000, C_ERET, 1'b0, 32'h800, 32'h0);
    idleCycles(3'b000, 32'h200, 4);

    // cli holds a request off, sti releases it
    $display("[TB] cli/sti gating");
    applyStimulus(3'b000, C_CLI, 1'b0, 32'h300, 32'h0);
    applyStimulus(3'b010, C_NONE, 1'b0, 32'h300, 32'h0);
    idleCycles(3'b000, 32'h300, 5);
    checkOutput("t3_pending_held", {29'b0, pending}, 32'h2);
    checkOutput("t3_no_take", {31'b0, int_take}, 32'h0);
    applyStimulus(3'b000, C_STI, 1'b0, 32'h300, 32'h0);
    checkOutput("t3_ie_set", {31'b0, ie}, 32'h1);
    checkOutput("t3_not_yet", {31'b0, int_take}, 32'h0);
    idleCycles(3'b000, 32'h300, 1);
    checkOutput("t3_take", {31'b0, int_take}, 32'h1);

    // mtc/mfc inside the ISR
    $display("[TB] mtc/mfc inside ISR");
    applyStimulus(3'b000, C_MTC, 1'b0, 32'h840, 32'h2000);
    int_ctrl = C_MFC;
    #1;
    checkOutput("t4_mfc_rdata", cp0_rdata, 32'h2000);
    applyStimulus(3'b000, C_MFC, 1'b0, 32'h844, 32'h0);
    applyStimulus(3'b000, C_ERET, 1'b0, 32'h848, 32'h0);
    checkOutput("t4_eret_epc", epc, 32'h2000);
    checkOutput("t4_in_service", {29'b0, in_service}, 32'h0);
    checkOutput("t4_ie", {31'b0, ie}, 32'h1);
    idleCycles(3'b000, 32'h300, 3);

    // Higher-priority request while source 0 is in service
    $display("[TB] source 2 during source 0 ISR");
    idleCycles(3'b001, 32'h100, 4);
    checkOutput("t5_vector_src0", int_vector, 32'h800);
    checkOutput("t5_epc_src0", epc, 32'h100);
    applyStimulus(3'b001, C_STI, 1'b0, 32'h800, 32'h0);
    idleCycles(3'b101, 32'h804, 4);
`ifdef NESTED_INT_EN
    checkOutput("t5_preempt", {31'b0, int_take}, 32'h1);
    checkOutput("t5_vector_src2", int_vector, 32'h880);
    checkOutput("t5_epc_nested", epc, 32'h804);
    checkOutput("t5_in_service", {29'b0, in_service}, 32'h5);
    applyStimulus(3'b101, C_ERET, 1'b0, 32'h880, 32'h0);
    checkOutput("t5_ret1", epc, 32'h804);
    applyStimulus(3'b101, C_ERET, 1'b0, 32'h808, 32'h0);
    checkOutput("t5_ret2", epc, 32'h100);
    checkOutput("t5_in_service_end", {29'b0, in_service}, 32'h0);
`else
    checkOutput("t5_no_preempt", {31'b0, int_take}, 32'h0);
    checkOutput("t5_src2_pending", {29'b0, pending}, 32'h4);
    applyStimulus(3'b101, C_ERET, 1'b0, 32'h804, 32'h0);
    checkOutput("t5_ret", epc, 32'h100);
    idleCycles(3'b101, 32'h100, 1);
    checkOutput("t5_take_src2", {31'b0, int_take}, 32'h1);
    checkOutput("t5_vector_src2", int_vector, 32'h880);
    applyStimulus(3'b101, C_ERET, 1'b0, 32'h880, 32'h0);
`endif
    idleCycles(3'b000, 32'h100, 4);

    // Asynchronous reset in the middle of an ISR
    $display("[TB] reset mid-ISR");
    idleCycles(3'b010, 32'h500, 4);
    checkOutput("t6_in_isr", {29'b0, in_service}, 32'h2);
    irq = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    checkResetValues();
    @(posedge clk);
    #2 rst_n = 1'b1;
    modelReset();

    // Random traffic against the model
    $display("[TB] random phase");
    r_irq = 3'b000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) r_irq[b] = ~r_irq[b];
      r = $urandom_range(0, 99);
      if (r < 55)      r_ctrl = C_NONE;
      else if (r < 65) r_ctrl = C_ERET;
      else if (r < 73) r_ctrl = C_CLI;
      else if (r < 85) r_ctrl = C_STI;
      else if (r < 92) r_ctrl = C_MTC;
      else             r_ctrl = C_MFC;
      applyStimulus(r_irq, r_ctrl, ($urandom_range(0, 19) == 0), $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
